exhaustive_vector_sweeper: RTL and testbench

- Parametrised, self-checking stimulus engine for small combinational logic blocks.
- Drives every one of the 2^N_IN input combinations in ascending binary order and holds each vector for DWELL cycles.
- Samples the DUT response on the last hold cycle and compares it against a golden response supplied by a reference model.
- Reports mismatch count, first failing vector, and pass/fail.
- Supports single-sweep and continuous modes.

---
 rtl/exhaustive_vector_sweeper_if.sv | 34 +++
 rtl/exhaustive_vector_sweeper.sv | 122 ++++++++++++
 tb/tb_exhaustive_vector_sweeper.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/exhaustive_vector_sweeper_if.sv
// Bus between the sweeper and its environment: control, stimulus/response and result signals.
// The sweeper connects through "master"; the driving environment connects through "slave".
interface exhaustive_vector_sweeper_if #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 2,
    parameter int CNT_W = 8
);
    logic             start;
    logic             stop;
    logic             mode_cont;
    logic [N_IN-1:0]  vec_out;
    logic [N_OUT-1:0] dut_resp;
    logic [N_OUT-1:0] exp_resp;
    logic             busy;
    logic             sample_strobe;
    logic             sweep_done;
    logic             done;
    logic [CNT_W-1:0] err_count;
    logic             first_err_valid;
    logic [N_IN-1:0]  first_err_vec;
    logic             pass;

    modport master (
        input  start, stop, mode_cont, dut_resp, exp_resp,
        output vec_out, busy, sample_strobe, sweep_done, done,
               err_count, first_err_valid, first_err_vec, pass
    );

    modport slave (
        output start, stop, mode_cont, dut_resp, exp_resp,
        input  vec_out, busy, sample_strobe, sweep_done, done,
               err_count, first_err_valid, first_err_vec, pass
    );
endinterface

// File: rtl/exhaustive_vector_sweeper.sv
// Walks every N_IN-bit input vector in ascending order, holding each for DWELL cycles,
// and compares the DUT response against the golden response on the last hold cycle.
module exhaustive_vector_sweeper #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 2,
    parameter int DWELL = 10,
    parameter int CNT_W = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    exhaustive_vector_sweeper_if.master sw
);
    localparam int DW_W = $clog2(DWELL + 1);
    localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             fvalid_q, fvalid_d;
    logic [N_IN-1:0]  fvec_q, fvec_d;
    logic             sdone_q, sdone_d;

    logic strobe;
    logic last_vec;
    logic mismatch;

    assign strobe   = (state_q == S_RUN) && (dwell_q == DW_LAST);
    assign last_vec = &vec_q;
    assign mismatch = (sw.dut_resp != sw.exp_resp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            vec_q    <= '0;
            dwell_q  <= '0;
            mode_q   <= 1'b0;
            err_q    <= '0;
            fvalid_q <= 1'b0;
            fvec_q   <= '0;
            sdone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            dwell_q  <= dwell_d;
            mode_q   <= mode_d;
            err_q    <= err_d;
            fvalid_q <= fvalid_d;
            fvec_q   <= fvec_d;
            sdone_q  <= sdone_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        dwell_d  = dwell_q;
        mode_d   = mode_q;
        err_d    = err_q;
        fvalid_d = fvalid_q;
        fvec_d   = fvec_q;
        sdone_d  = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (sw.start) begin
                    state_d  = S_RUN;
                    vec_d    = '0;
                    dwell_d  = '0;
                    mode_d   = sw.mode_cont;
                    err_d    = '0;
                    fvalid_d = 1'b0;
                    fvec_d   = '0;
                end
            end
            S_RUN: begin
                // stop pre-empts the compare and any vector advance this cycle
                if (sw.stop) begin
                    state_d = S_IDLE;
                    vec_d   = '0;
                    dwell_d = '0;
                end else if (strobe) begin
                    if (mismatch) begin
                        if (err_q != {CNT_W{1'b1}}) err_d = err_q + CNT_W'(1);
                        if (!fvalid_q) begin
                            fvalid_d = 1'b1;
                            fvec_d   = vec_q;
                        end
                    end
                    if (last_vec) begin
                        sdone_d = 1'b1;
                        if (mode_q) begin
                            vec_d   = '0;
                            dwell_d = '0;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        vec_d   = vec_q + N_IN'(1);
                        dwell_d = '0;
                    end
                end else begin
                    dwell_d = dwell_q + DW_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign sw.vec_out         = vec_q;
    assign sw.busy            = (state_q == S_RUN);
    assign sw.sample_strobe   = strobe;
    assign sw.sweep_done      = sdone_q;
    assign sw.done            = (state_q == S_DONE);
    assign sw.err_count       = err_q;
    assign sw.first_err_valid = fvalid_q;
    assign sw.first_err_vec   = fvec_q;
    assign sw.pass            = (state_q == S_DONE) && (err_q == '0);
endmodule

// File: tb/tb_exhaustive_vector_sweeper.sv
// Directed bench for the sweeper: single sweep, forced mismatches, continuous mode with stop,
// counter saturation (CNT_W=2 instance), asynchronous reset mid-sweep and restart from DONE.
module tb_exhaustive_vector_sweeper;
    logic clk;
    logic rst;
    logic [7:0] bad;
    int checks = 0;
    int errors = 0;
    int n_strobe = 0;
    int n_sdone = 0;
    int n_sdone2 = 0;

    exhaustive_vector_sweeper_if #(.N_IN(3), .N_OUT(2), .CNT_W(8)) bus ();
    exhaustive_vector_sweeper_if #(.N_IN(3), .N_OUT(2), .CNT_W(2)) bus2 ();

    exhaustive_vector_sweeper #(.N_IN(3), .N_OUT(2), .DWELL(10), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .sw(bus)
    );
    exhaustive_vector_sweeper #(.N_IN(3), .N_OUT(2), .DWELL(10), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .sw(bus2)
    );

    function automatic logic [1:0] gold(input logic [2:0] v);
        return {v[2] ^ v[0], v[1] & ~v[0]};
    endfunction

    assign bus.exp_resp  = gold(bus.vec_out);
    assign bus.dut_resp  = bad[bus.vec_out] ? (gold(bus.vec_out) ^ 2'b01) : gold(bus.vec_out);
    assign bus2.exp_resp = gold(bus2.vec_out);
    assign bus2.dut_resp = ~gold(bus2.vec_out);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.sample_strobe) n_strobe++;
        if (bus.sweep_done) n_sdone++;
        if (bus2.sweep_done) n_sdone2++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        while (bus.done !== 1'b1 && cyc < 300) begin
            step();
            cyc++;
        end
        check(tag, 32'(cyc < 300), 1);
    endtask

    task automatic wait_vec(input logic [2:0] v, output int cyc);
        cyc = 0;
        while (bus.vec_out !== v && cyc < 300) begin
            step();
            cyc++;
        end
        check("wait_vec_timeout", 32'(cyc < 300), 1);
    endtask

    initial begin
        int s0, d0, cyc;
        rst = 1'b1;
        bad = 8'h00;
        bus.start = 1'b0; bus.stop = 1'b0; bus.mode_cont = 1'b0;
        bus2.start = 1'b0; bus2.stop = 1'b0; bus2.mode_cont = 1'b0;
        step(); step();
        check("rst_vec", 32'(bus.vec_out), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_err", 32'(bus.err_count), 0);
        check("rst_fvalid", 32'(bus.first_err_valid), 0);
        check("rst_pass", 32'(bus.pass), 0);
        check("rst_strobe", 32'(bus.sample_strobe), 0);
        rst = 1'b0;
        step();

        // single clean sweep
        pulse_start();
        s0 = n_strobe; d0 = n_sdone;
        for (int k = 0; k < 80; k++) begin
            check("t1_vec", 32'(bus.vec_out), 32'(k / 10));
            check("t1_busy", 32'(bus.busy), 1);
            step();
        end
        check("t1_done", 32'(bus.done), 1);
        check("t1_sdone", 32'(bus.sweep_done), 1);
        check("t1_pass", 32'(bus.pass), 1);
        check("t1_err", 32'(bus.err_count), 0);
        check("t1_busy_off", 32'(bus.busy), 0);
        check("t1_vec_hold", 32'(bus.vec_out), 7);
        check("t1_strobes", 32'(n_strobe - s0), 8);
        step();
        check("t1_sdone_pulse", 32'(bus.sweep_done), 0);
        check("t1_sdone_cnt", 32'(n_sdone - d0), 1);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        check("t1_stop_ignored", 32'(bus.done), 1);

        // mismatches at vectors 5 and 6
        bad = 8'b0110_0000;
        pulse_start();
        wait_done("t2_timeout");
        check("t2_err", 32'(bus.err_count), 2);
        check("t2_fvalid", 32'(bus.first_err_valid), 1);
        check("t2_fvec", 32'(bus.first_err_vec), 5);
        check("t2_pass", 32'(bus.pass), 0);

        // restart from DONE clears statistics
        bad = 8'h00;
        pulse_start();
        check("t6_err", 32'(bus.err_count), 0);
        check("t6_fvalid", 32'(bus.first_err_valid), 0);
        check("t6_fvec", 32'(bus.first_err_vec), 0);
        check("t6_busy", 32'(bus.busy), 1);
        check("t6_vec", 32'(bus.vec_out), 0);
        check("t6_done", 32'(bus.done), 0);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        check("t6_stop_busy", 32'(bus.busy), 0);

        // continuous mode, 3 sweeps, mismatch at vector 3
        bad = 8'b0000_1000;
        bus.mode_cont = 1'b1;
        pulse_start();
        bus.mode_cont = 1'b0;
        d0 = n_sdone; cyc = 0;
        while ((n_sdone - d0) < 3 && cyc < 1000) begin
            step();
            cyc++;
        end
        check("t3_timeout", 32'(cyc < 1000), 1);
        check("t3_wrapped_busy", 32'(bus.busy), 1);
        check("t3_wrapped_vec", 32'(bus.vec_out), 0);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        check("t3_sdones", 32'(n_sdone - d0), 3);
        check("t3_busy", 32'(bus.busy), 0);
        check("t3_vec", 32'(bus.vec_out), 0);
        check("t3_done", 32'(bus.done), 0);
        check("t3_err", 32'(bus.err_count), 3);
        check("t3_fvec", 32'(bus.first_err_vec), 3);
        check("t3_fvalid", 32'(bus.first_err_valid), 1);
        step();
        check("t3_idle_hold", 32'(bus.busy), 0);

        // start during RUN ignored, async reset at vector 4
        bad = 8'b0000_0010;
        pulse_start();
        wait_vec(3'd2, cyc);
        check("t5_vec2_time", 32'(cyc), 20);
        pulse_start();
        check("t5_start_ignored_vec", 32'(bus.vec_out), 2);
        wait_vec(3'd4, cyc);
        check("t5_vec4_time", 32'(cyc + 21), 40);
        check("t5_err_pre", 32'(bus.err_count), 1);
        d0 = n_sdone;
        #3 rst = 1'b1;
        #1;
        check("t5_rst_vec", 32'(bus.vec_out), 0);
        check("t5_rst_busy", 32'(bus.busy), 0);
        check("t5_rst_err", 32'(bus.err_count), 0);
        check("t5_rst_fvalid", 32'(bus.first_err_valid), 0);
        step(); step();
        rst = 1'b0;
        step();
        check("t5_idle", 32'(bus.busy), 0);
        check("t5_no_sdone", 32'(n_sdone - d0), 0);
        bad = 8'h00;
        pulse_start();
        check("t5_restart_vec", 32'(bus.vec_out), 0);
        check("t5_restart_busy", 32'(bus.busy), 1);
        for (int k = 0; k < 10; k++) step();
        check("t5_restart_vec1", 32'(bus.vec_out), 1);

        // CNT_W=2 saturation, every vector mismatches
        bus2.start = 1'b1;
        step();
        bus2.start = 1'b0;
        cyc = 0;
        while (bus2.done !== 1'b1 && cyc < 300) begin
            step();
            cyc++;
        end
        check("t4_timeout", 32'(cyc < 300), 1);
        check("t4_err_sat", 32'(bus2.err_count), 3);
        check("t4_fvec", 32'(bus2.first_err_vec), 0);
        check("t4_fvalid", 32'(bus2.first_err_valid), 1);
        check("t4_pass", 32'(bus2.pass), 0);
        step();
        check("t4_sdones", 32'(n_sdone2), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
